// File: rtl/regfile_mp.sv
// Multi-port integer register file: x0 hardwired, per-register pending scoreboard, sequenced clear engine.
// Reads are combinational; writes and allocs land on the next edge; a clear holds busy for NREGS-1 cycles.
// No backpressure: while busy, writes, allocs and clear requests are dropped, and reads return zero.
// Optional same-cycle write-to-read bypass is enabled by defining REGFILE_BYPASS_EN.
module regfile_mp #(
    parameter int XLEN  = 64,
    parameter int NREGS = 32,
    parameter int NRD   = 2,
    parameter int NWR   = 1,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD*AW-1:0]   ra,
    output logic [NRD*XLEN-1:0] rd,
    output logic [NRD-1:0]      rpend,
    input  logic [NWR*AW-1:0]   wa,
    input  logic [NWR*XLEN-1:0] wd,
    input  logic [NWR-1:0]      we,
    input  logic                alloc_en,
    input  logic [AW-1:0]       alloc_addr,
    input  logic                clr_req,
    output logic                busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t          state, state_nxt;
    logic [AW-1:0]   cnt, cnt_nxt;
    logic [XLEN-1:0] regs [NREGS];
    logic [NREGS-1:0] pend;

    assign busy = (state == CLEAR);

    // Clear engine state and sweep counter; reset always restarts the sweep from register 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= CLEAR;
            cnt   <= AW'(1);
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Clear engine next state: a request while sweeping is ignored, and the counter holds at the terminal value.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (clr_req) begin
                    state_nxt = CLEAR;
                    cnt_nxt   = AW'(1);
                end
            end
            CLEAR: begin
                if (cnt == AW'(NREGS - 1)) begin
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt + AW'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Array update: the sweep zeroes one register per cycle; otherwise the highest write port wins on a collision.
    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            regs[cnt] <= '0;
        end else if (!rst) begin
            for (int j = 0; j < NWR; j++) begin
                if (we[j] && (wa[j*AW +: AW] != '0)) begin
                    regs[wa[j*AW +: AW]] <= wd[j*XLEN +: XLEN];
                end
            end
        end
    end

    // Pending scoreboard: writes retire a destination, and an alloc to the same register in the same cycle overrides the retire.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend <= '0;
        end else if (!busy) begin
            if (clr_req) begin
                pend <= '0;
            end else begin
                for (int j = 0; j < NWR; j++) begin
                    if (we[j] && (wa[j*AW +: AW] != '0)) begin
                        pend[wa[j*AW +: AW]] <= 1'b0;
                    end
                end
                if (alloc_en && (alloc_addr != '0)) begin
                    pend[alloc_addr] <= 1'b1;
                end
            end
        end
    end

    // Read ports: x0 and the busy window return zero; the optional bypass forwards same-cycle write data.
    always_comb begin
        rd    = '0;
        rpend = '0;
        for (int i = 0; i < NRD; i++) begin
            if (!busy && (ra[i*AW +: AW] != '0)) begin
                rd[i*XLEN +: XLEN] = regs[ra[i*AW +: AW]];
                rpend[i]           = pend[ra[i*AW +: AW]];
`ifdef REGFILE_BYPASS_EN
                for (int j = 0; j < NWR; j++) begin
                    if (we[j] && (wa[j*AW +: AW] == ra[i*AW +: AW])) begin
                        rd[i*XLEN +: XLEN] = wd[j*XLEN +: XLEN];
                        if (!(alloc_en && (alloc_addr == ra[i*AW +: AW]))) begin
                            rpend[i] = 1'b0;
                        end
                    end
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp with two write ports and two read ports.
// Expected read results come from a behavioural model and are queued, then popped as the DUT is read.
module tb_regfile_mp;

    localparam int XLEN  = 64;
    localparam int NREGS = 32;
    localparam int NRD   = 2;
    localparam int NWR   = 2;
    localparam int AW    = 5;

    logic                clk = 1'b0;
    logic                rst;
    logic [NRD*AW-1:0]   ra;
    logic [NRD*XLEN-1:0] rd;
    logic [NRD-1:0]      rpend;
    logic [NWR*AW-1:0]   wa;
    logic [NWR*XLEN-1:0] wd;
    logic [NWR-1:0]      we;
    logic                alloc_en;
    logic [AW-1:0]       alloc_addr;
    logic                clr_req;
    logic                busy;

    always #5 clk = ~clk;

    regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR)) dut (
        .clk        (clk),
        .rst        (rst),
        .ra         (ra),
        .rd         (rd),
        .rpend      (rpend),
        .wa         (wa),
        .wd         (wd),
        .we         (we),
        .alloc_en   (alloc_en),
        .alloc_addr (alloc_addr),
        .clr_req    (clr_req),
        .busy       (busy)
    );

    typedef struct {
        logic [AW-1:0]   a;
        logic [XLEN-1:0] d;
        logic            p;
    } exp_t;

    exp_t            exp_q[$];
    logic [XLEN-1:0] m_regs [NREGS];
    logic            m_pend [NREGS];
    int              n_checks = 0;
    int              n_fail   = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        we         = '0;
        wa         = '0;
        wd         = '0;
        alloc_en   = 1'b0;
        alloc_addr = '0;
        clr_req    = 1'b0;
    endtask

    task automatic push_exp(input logic [AW-1:0] a);
        exp_t e;
        e.a = a;
        e.d = (a == '0) ? '0 : m_regs[a];
        e.p = (a == '0) ? 1'b0 : m_pend[a];
        exp_q.push_back(e);
    endtask

    task automatic model_clear();
        for (int k = 0; k < NREGS; k++) begin
            m_regs[k] = '0;
            m_pend[k] = 1'b0;
        end
    endtask

    task automatic test_reset();
        int   cycles;
        exp_t e;
        idle_inputs();
        ra  = {5'd3, 5'd5};
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if (busy !== 1'b1 || rd !== '0 || rpend !== '0) begin
            n_fail++;
            $display("FAIL reset_state: busy=%b rd=%h rpend=%b, want busy=1 rd=0 rpend=0", busy, rd, rpend);
        end
        cycles = 0;
        while (busy === 1'b1 && cycles < 100) begin
            cycles++;
            tick();
        end
        n_checks++;
        if (cycles !== 31) begin
            n_fail++;
            $display("FAIL reset_busy_len: got %0d busy cycles, want 31", cycles);
        end
        model_clear();
        for (int a = 0; a < NREGS; a++) push_exp(AW'(a));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            @(negedge clk);
            ra = {5'd0, e.a};
            #1;
            n_checks++;
            if (rd[XLEN-1:0] !== e.d || rpend[0] !== e.p) begin
                n_fail++;
                $display("FAIL reset_read r%0d: rd=%h rpend=%b, want rd=%h rpend=%b", e.a, rd[XLEN-1:0], rpend[0], e.d, e.p);
            end
        end
    endtask

    task automatic test_write_read();
        exp_t            e;
        logic [XLEN-1:0] v;
        logic [XLEN-1:0] want;
        v = 64'hDEADBEEF_00000001;
        tick();
        we          = 2'b01;
        wa[AW-1:0]  = 5'd5;
        wd[XLEN-1:0] = v;
        ra          = {5'd0, 5'd5};
        #1;
`ifdef REGFILE_BYPASS_EN
        want = v;
`else
        want = m_regs[5];
`endif
        n_checks++;
        if (rd[XLEN-1:0] !== want) begin
            n_fail++;
            $display("FAIL write_same_cycle: rd=%h, want %h", rd[XLEN-1:0], want);
        end
        tick();
        idle_inputs();
        m_regs[5] = v;
        m_pend[5] = 1'b0;
        push_exp(5'd5);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            @(negedge clk);
            ra = {5'd0, e.a};
            #1;
            n_checks++;
            if (rd[XLEN-1:0] !== e.d || rpend[0] !== e.p) begin
                n_fail++;
                $display("FAIL write_read r%0d: rd=%h rpend=%b, want rd=%h rpend=%b", e.a, rd[XLEN-1:0], rpend[0], e.d, e.p);
            end
        end
    endtask

    task automatic test_zero_reg();
        exp_t e;
        tick();
        we           = 2'b01;
        wa[AW-1:0]   = 5'd0;
        wd[XLEN-1:0] = '1;
        alloc_en     = 1'b1;
        alloc_addr   = 5'd0;
        ra           = {5'd0, 5'd0};
        #1;
        n_checks++;
        if (rd[XLEN-1:0] !== '0 || rpend[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_same_cycle: rd=%h rpend=%b, want 0 0", rd[XLEN-1:0], rpend[0]);
        end
        tick();
        idle_inputs();
        push_exp(5'd0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            @(negedge clk);
            ra = {5'd0, e.a};
            #1;
            n_checks++;
            if (rd[XLEN-1:0] !== e.d || rpend[0] !== e.p) begin
                n_fail++;
                $display("FAIL zero_reg r%0d: rd=%h rpend=%b, want rd=%h rpend=%b", e.a, rd[XLEN-1:0], rpend[0], e.d, e.p);
            end
        end
    endtask

    task automatic test_write_priority();
        exp_t            e;
        logic [XLEN-1:0] want;
        tick();
        we = 2'b11;
        wa = {5'd7, 5'd7};
        wd = {64'h22, 64'h11};
        ra = {5'd0, 5'd7};
        #1;
`ifdef REGFILE_BYPASS_EN
        want = 64'h22;
`else
        want = m_regs[7];
`endif
        n_checks++;
        if (rd[XLEN-1:0] !== want) begin
            n_fail++;
            $display("FAIL priority_same_cycle: rd=%h, want %h", rd[XLEN-1:0], want);
        end
        tick();
        m_regs[7] = 64'h22;
        we = 2'b11;
        wa = {5'd9, 5'd8};
        wd = {64'hB0B0_0000_0000_000B, 64'hA0A0_0000_0000_000A};
        tick();
        idle_inputs();
        m_regs[8] = 64'hA0A0_0000_0000_000A;
        m_regs[9] = 64'hB0B0_0000_0000_000B;
        push_exp(5'd7);
        push_exp(5'd8);
        push_exp(5'd9);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            @(negedge clk);
            ra = {5'd0, e.a};
            #1;
            n_checks++;
            if (rd[XLEN-1:0] !== e.d || rpend[0] !== e.p) begin
                n_fail++;
                $display("FAIL write_priority r%0d: rd=%h rpend=%b, want rd=%h rpend=%b", e.a, rd[XLEN-1:0], rpend[0], e.d, e.p);
            end
        end
    endtask

    task automatic test_alloc();
        exp_t            e;
        logic [XLEN-1:0] want_d;
        logic            want_p;
        for (int step = 0; step < 3; step++) begin
            tick();
            ra = {5'd0, 5'd3};
            if (step == 0) begin
                alloc_en   = 1'b1;
                alloc_addr = 5'd3;
            end else if (step == 1) begin
                alloc_en     = 1'b1;
                alloc_addr   = 5'd3;
                we           = 2'b01;
                wa[AW-1:0]   = 5'd3;
                wd[XLEN-1:0] = 64'h5;
            end else begin
                we                = 2'b10;
                wa[2*AW-1:AW]     = 5'd3;
                wd[2*XLEN-1:XLEN] = 64'h6;
            end
            #1;
            want_d = m_regs[3];
            want_p = m_pend[3];
`ifdef REGFILE_BYPASS_EN
            if (step == 1) want_d = 64'h5;
            if (step == 2) begin
                want_d = 64'h6;
                want_p = 1'b0;
            end
`endif
            n_checks++;
            if (rd[XLEN-1:0] !== want_d || rpend[0] !== want_p) begin
                n_fail++;
                $display("FAIL alloc_same_cycle step%0d: rd=%h rpend=%b, want rd=%h rpend=%b", step, rd[XLEN-1:0], rpend[0], want_d, want_p);
            end
            tick();
            idle_inputs();
            if (step == 0) m_pend[3] = 1'b1;
            if (step == 1) m_regs[3] = 64'h5;
            if (step == 2) begin
                m_regs[3] = 64'h6;
                m_pend[3] = 1'b0;
            end
            push_exp(5'd3);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                @(negedge clk);
                ra = {5'd0, e.a};
                #1;
                n_checks++;
                if (rd[XLEN-1:0] !== e.d || rpend[0] !== e.p) begin
                    n_fail++;
                    $display("FAIL alloc step%0d r%0d: rd=%h rpend=%b, want rd=%h rpend=%b", step, e.a, rd[XLEN-1:0], rpend[0], e.d, e.p);
                end
            end
        end
    endtask

    task automatic test_clear();
        exp_t e;
        int   cycles;
        int   bad;
        tick();
        for (int k = 1; k < NREGS; k++) begin
            we           = 2'b01;
            wa[AW-1:0]   = AW'(k);
            wd[XLEN-1:0] = {32'hC0DE0000, 32'(k)};
            tick();
            m_regs[k] = {32'hC0DE0000, 32'(k)};
            m_pend[k] = 1'b0;
        end
        idle_inputs();
        alloc_en   = 1'b1;
        alloc_addr = 5'd4;
        tick();
        idle_inputs();
        m_pend[4] = 1'b1;
        push_exp(5'd1);
        push_exp(5'd4);
        push_exp(5'd31);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            @(negedge clk);
            ra = {5'd0, e.a};
            #1;
            n_checks++;
            if (rd[XLEN-1:0] !== e.d || rpend[0] !== e.p) begin
                n_fail++;
                $display("FAIL clear_preload r%0d: rd=%h rpend=%b, want rd=%h rpend=%b", e.a, rd[XLEN-1:0], rpend[0], e.d, e.p);
            end
        end
        tick();
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        model_clear();
        cycles = 0;
        bad    = 0;
        while (busy === 1'b1 && cycles < 100) begin
            we           = 2'b01;
            wa[AW-1:0]   = AW'((cycles % 31) + 1);
            wd[XLEN-1:0] = '1;
            alloc_en     = 1'b1;
            alloc_addr   = AW'((cycles % 31) + 1);
            clr_req      = (cycles == 5 || cycles == 29);
            ra           = {5'd4, AW'((cycles % 31) + 1)};
            #1;
            if (rd !== '0 || rpend !== '0) bad++;
            cycles++;
            tick();
        end
        idle_inputs();
        n_checks++;
        if (cycles !== 31) begin
            n_fail++;
            $display("FAIL clear_busy_len: got %0d busy cycles, want 31", cycles);
        end
        n_checks++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL clear_busy_reads: got %0d nonzero read cycles, want 0", bad);
        end
        for (int a = 0; a < NREGS; a++) push_exp(AW'(a));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            @(negedge clk);
            ra = {5'd0, e.a};
            #1;
            n_checks++;
            if (rd[XLEN-1:0] !== e.d || rpend[0] !== e.p) begin
                n_fail++;
                $display("FAIL clear_result r%0d: rd=%h rpend=%b, want rd=%h rpend=%b", e.a, rd[XLEN-1:0], rpend[0], e.d, e.p);
            end
        end
    endtask

    task automatic test_rst_mid_clear();
        exp_t e;
        int   cycles;
        tick();
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        for (int k = 0; k < 10; k++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        cycles = 0;
        while (busy === 1'b1 && cycles < 100) begin
            cycles++;
            tick();
        end
        n_checks++;
        if (cycles !== 31) begin
            n_fail++;
            $display("FAIL rst_mid_clear_len: got %0d busy cycles, want 31", cycles);
        end
        we                = 2'b10;
        wa[2*AW-1:AW]     = 5'd12;
        wd[2*XLEN-1:XLEN] = 64'h1234_5678_9ABC_DEF0;
        tick();
        idle_inputs();
        m_regs[12] = 64'h1234_5678_9ABC_DEF0;
        push_exp(5'd12);
        push_exp(5'd13);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            @(negedge clk);
            ra = {e.a, 5'd0};
            #1;
            n_checks++;
            if (rd[2*XLEN-1:XLEN] !== e.d || rpend[1] !== e.p) begin
                n_fail++;
                $display("FAIL after_restart r%0d: rd=%h rpend=%b, want rd=%h rpend=%b", e.a, rd[2*XLEN-1:XLEN], rpend[1], e.d, e.p);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        ra  = '0;
        idle_inputs();
        model_clear();
        test_reset();
        test_write_read();
        test_zero_reg();
        test_write_priority();
        test_alloc();
        test_clear();
        test_rst_mid_clear();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
